// File: rtl/md5_hbf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md5_hbf_pkg
// Brief    : Shared constants and UART receiver state encoding for the MD5
//            search engine serial paths.
// Revision : 1.0 - initial release
// ============================================================================
package md5_hbf_pkg;

    localparam int MD5_BYTES = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte
// Brief    : 8N1 UART byte receiver with a 2-FF input synchroniser; emits
//            one-cycle byte_strobe / frame_err pulses at the stop-bit sample.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import md5_hbf_pkg::*;
#(
    parameter int CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic       frame_err,
    output logic       busy
);

    localparam int                 c_cnt_w = $clog2(CLK_DIV + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(CLK_DIV);
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(CLK_DIV / 2);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic               r_sync1, r_sync2, r_prev;
    rx_state_t          r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic               w_tick, w_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign w_fall = r_prev & ~r_sync2;
    // The bit timer counts down to 1; that cycle is the mid-bit sample point.
    assign w_tick = (r_cnt == c_one);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_data_nxt  = r_data;
        byte_strobe = 1'b0;
        frame_err   = 1'b0;
        if (r_state != RX_IDLE) begin
            w_cnt_nxt = w_tick ? c_full : (r_cnt - c_one);
        end
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = c_half;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (r_sync2) begin
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_state_nxt = RX_DATA;
                        w_bit_nxt   = '0;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    w_data_nxt = {r_sync2, r_data[7:1]};
                    w_bit_nxt  = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Return to idle at mid stop bit so back-to-back frames keep up.
                if (w_tick) begin
                    w_state_nxt = RX_IDLE;
                    if (r_sync2) begin
                        byte_strobe = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign byte_data = r_data;
    assign busy      = (r_state != RX_IDLE);

endmodule
`default_nettype wire

// File: rtl/hash_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : hash_uart_rx
// Brief    : Assembles NBYTES UART bytes into one digest word and presents it
//            with a valid/ack handshake, overrun flag and inter-byte timeout.
// Revision : 1.0 - initial release
// ============================================================================
module hash_uart_rx
    import md5_hbf_pkg::*;
#(
    parameter int CLK_DIV     = 104,
    parameter int NBYTES      = MD5_BYTES,
    parameter int GAP_TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    output logic [0:8*NBYTES-1] hash_out,
    output logic                hash_valid,
    input  logic                hash_ack,
    output logic                frame_err,
    output logic                overrun,
    output logic                rx_led
);

    localparam int                 c_cnt_w   = $clog2(NBYTES + 1);
    localparam int                 c_gap_w   = $clog2(GAP_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(NBYTES - 1);
    localparam logic [c_gap_w-1:0] c_gap_max = c_gap_w'(GAP_TIMEOUT);

    logic [7:0]          w_byte;
    logic                w_strobe, w_ferr, w_busy;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_gap_w-1:0]  r_gap;
    logic [0:8*NBYTES-1] r_shift;
    logic                r_done;

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_byte (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .byte_data   (w_byte),
        .byte_strobe (w_strobe),
        .frame_err   (w_ferr),
        .busy        (w_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_gap   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_ferr) begin
                r_count <= '0;
                r_gap   <= '0;
            end else if (w_strobe) begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (r_count == c_cnt_w'(k)) begin
                        r_shift[8*k +: 8] <= w_byte;
                    end
                end
                r_gap <= '0;
                if (r_count == c_last) begin
                    r_count <= '0;
                    r_done  <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_busy || (r_count == '0)) begin
                r_gap <= '0;
            end else if (r_gap == c_gap_max) begin
                // Sender stalled mid-digest: forget the partial bytes.
                r_count <= '0;
                r_gap   <= '0;
            end else begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hash_out   <= '0;
            hash_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= w_ferr;
            if (r_done) begin
                hash_out   <= r_shift;
                hash_valid <= 1'b1;
                if (hash_valid && !hash_ack) begin
                    overrun <= 1'b1;
                end
            end else if (hash_ack) begin
                hash_valid <= 1'b0;
            end
        end
    end

    assign rx_led = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_hash_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_uart_rx
// Brief    : Self-checking bench for hash_uart_rx against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hash_uart_rx;

    localparam int CLK_DIV     = 16;
    localparam int NBYTES      = 16;
    localparam int GAP_TIMEOUT = 2000;

    logic           clk = 1'b0;
    logic           reset;
    logic           rx;
    logic           hash_ack;
    logic [0:127]   hash_out;
    logic           hash_valid;
    logic           frame_err;
    logic           overrun;
    logic           rx_led;

    always #5 clk = ~clk;

    hash_uart_rx #(
        .CLK_DIV     (CLK_DIV),
        .NBYTES      (NBYTES),
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .hash_out   (hash_out),
        .hash_valid (hash_valid),
        .hash_ack   (hash_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_led     (rx_led)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int ferr_cnt     = 0;

    always @(posedge clk) begin
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    // Reference model: accepted bytes collect in a queue; a full queue is a digest.
    logic [7:0]   q[$];
    logic [127:0] exp_hash    = '0;
    bit           exp_valid   = 1'b0;
    bit           exp_overrun = 1'b0;

    task automatic model_accept(input logic [7:0] b, input bit ack_now);
        q.push_back(b);
        if (q.size() == NBYTES) begin
            for (int k = 0; k < NBYTES; k++) exp_hash[127-8*k -: 8] = q[k];
            if (exp_valid && !ack_now) exp_overrun = 1'b1;
            exp_valid = 1'b1;
            q.delete();
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_hash    = '0;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
    endtask

    // Drives one frame; reports when rx_led fell during the stop bit and the
    // hash_valid values on that cycle and the one after.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit ack_done,
                             output int fell, output logic v_fall, output logic v_after,
                             output logic led_stop);
        fell    = -1;
        v_fall  = 1'bx;
        v_after = 1'bx;
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop_ok;
        for (int i = 0; i < CLK_DIV; i++) begin
            @(negedge clk);
            if (i == 0) led_stop = rx_led;
            if (fell < 0) begin
                if (rx_led === 1'b0) begin
                    fell   = i;
                    v_fall = hash_valid;
                    if (ack_done) hash_ack = 1'b1;
                end
            end else if (i == fell + 1) begin
                v_after  = hash_valid;
                hash_ack = 1'b0;
            end
        end
        hash_ack = 1'b0;
        rx       = 1'b1;
    endtask

    task automatic send_digest(input logic [7:0] d [NBYTES], input bit ack_done,
                               output int fell, output logic v_fall, output logic v_after,
                               output logic led_stop);
        for (int k = 0; k < NBYTES; k++) begin
            send_byte(d[k], 1'b1, (k == NBYTES-1) && ack_done, fell, v_fall, v_after, led_stop);
            model_accept(d[k], (k == NBYTES-1) && ack_done);
        end
    endtask

    task automatic pulse_ack();
        hash_ack = 1'b1;
        @(negedge clk);
        hash_ack  = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic rand_digest(output logic [7:0] d [NBYTES]);
        for (int k = 0; k < NBYTES; k++) d[k] = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; hash_ack = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        tests_run++; if (hash_out !== exp_hash) begin tests_failed++; $display("FAIL reset_hash_out: got %h expected %h", hash_out, exp_hash); end
        tests_run++; if (hash_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_hash_valid: got %b expected 0", hash_valid); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        tests_run++; if (rx_led !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_led: got %b expected 0", rx_led); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_digest();
        logic [7:0] d [NBYTES];
        int fell; logic vf, va, led;
        int c0 = ferr_cnt;
        d = '{8'h82, 8'hcf, 8'h9f, 8'ha6, 8'h47, 8'hdd, 8'h1b, 8'h3f,
              8'hbd, 8'h9d, 8'he7, 8'h1b, 8'hbf, 8'hb8, 8'h3f, 8'hb2};
        send_digest(d, 1'b0, fell, vf, va, led);
        tests_run++; if (led !== 1'b1) begin tests_failed++; $display("FAIL digest_rx_led_busy: got %b expected 1", led); end
        tests_run++;
        if (fell < 0) begin
            tests_failed++; $display("FAIL digest_stop_sample: got no rx_led fall expected fall within stop bit");
        end else if (vf !== 1'b0 || va !== 1'b1) begin
            tests_failed++; $display("FAIL digest_valid_latency: got %b%b expected 01", vf, va);
        end
        tests_run++; if (hash_out !== 128'h82cf9fa647dd1b3fbd9de71bbfb83fb2) begin tests_failed++; $display("FAIL digest_hash_out: got %h expected 82cf9fa647dd1b3fbd9de71bbfb83fb2", hash_out); end
        tests_run++; if (hash_valid !== exp_valid) begin tests_failed++; $display("FAIL digest_hash_valid: got %b expected %b", hash_valid, exp_valid); end
        tests_run++; if (ferr_cnt !== c0) begin tests_failed++; $display("FAIL digest_frame_err: got %0d pulses expected 0", ferr_cnt - c0); end
        tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL digest_overrun: got %b expected %b", overrun, exp_overrun); end
    endtask

    task automatic test_ack();
        logic [127:0] held = exp_hash;
        pulse_ack();
        tests_run++; if (hash_valid !== exp_valid) begin tests_failed++; $display("FAIL ack_valid_clear: got %b expected %b", hash_valid, exp_valid); end
        repeat (3) @(negedge clk);
        tests_run++; if (hash_out !== held) begin tests_failed++; $display("FAIL ack_hash_hold: got %h expected %h", hash_out, held); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d [NBYTES];
        int fell; logic vf, va, led;
        int c0 = ferr_cnt;
        for (int k = 0; k < 4; k++) begin
            d[k] = 8'($urandom);
            send_byte(d[k], 1'b1, 1'b0, fell, vf, va, led);
            model_accept(d[k], 1'b0);
        end
        send_byte(8'($urandom), 1'b0, 1'b0, fell, vf, va, led);
        q.delete();
        repeat (2*CLK_DIV) @(negedge clk);
        tests_run++; if (ferr_cnt - c0 !== 1) begin tests_failed++; $display("FAIL ferr_pulse_count: got %0d expected 1", ferr_cnt - c0); end
        for (int k = 0; k < NBYTES; k++) d[k] = 8'(k);
        send_digest(d, 1'b0, fell, vf, va, led);
        tests_run++; if (hash_out !== 128'h000102030405060708090a0b0c0d0e0f) begin tests_failed++; $display("FAIL ferr_recover_hash: got %h expected 000102030405060708090a0b0c0d0e0f", hash_out); end
        tests_run++; if (hash_valid !== exp_valid) begin tests_failed++; $display("FAIL ferr_recover_valid: got %b expected %b", hash_valid, exp_valid); end
        pulse_ack();
    endtask

    task automatic test_gap_timeout();
        logic [7:0] d [NBYTES];
        int fell; logic vf, va, led;
        for (int k = 0; k < 7; k++) begin
            d[k] = 8'($urandom);
            send_byte(d[k], 1'b1, 1'b0, fell, vf, va, led);
            model_accept(d[k], 1'b0);
        end
        repeat (2100) @(negedge clk);
        q.delete();
        tests_run++; if (hash_valid !== exp_valid) begin tests_failed++; $display("FAIL gap_valid_untouched: got %b expected %b", hash_valid, exp_valid); end
        for (int k = 0; k < NBYTES; k++) d[k] = 8'(8'hff - k);
        send_digest(d, 1'b0, fell, vf, va, led);
        tests_run++; if (hash_out !== 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0) begin tests_failed++; $display("FAIL gap_hash_out: got %h expected fffefdfcfbfaf9f8f7f6f5f4f3f2f1f0", hash_out); end
        tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL gap_overrun: got %b expected %b", overrun, exp_overrun); end
        pulse_ack();
    endtask

    task automatic test_glitch();
        logic [7:0] d [NBYTES];
        int fell; logic vf, va, led;
        rand_digest(d);
        for (int k = 0; k < 5; k++) begin
            send_byte(d[k], 1'b1, 1'b0, fell, vf, va, led);
            model_accept(d[k], 1'b0);
        end
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3*CLK_DIV) @(negedge clk);
        tests_run++; if (rx_led !== 1'b0) begin tests_failed++; $display("FAIL glitch_rx_led: got %b expected 0", rx_led); end
        for (int k = 5; k < NBYTES; k++) begin
            send_byte(d[k], 1'b1, 1'b0, fell, vf, va, led);
            model_accept(d[k], 1'b0);
        end
        tests_run++; if (hash_out !== exp_hash) begin tests_failed++; $display("FAIL glitch_hash_out: got %h expected %h", hash_out, exp_hash); end
        tests_run++; if (hash_valid !== exp_valid) begin tests_failed++; $display("FAIL glitch_hash_valid: got %b expected %b", hash_valid, exp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [NBYTES];
        int fell; logic vf, va, led;
        rand_digest(d);
        send_digest(d, 1'b1, fell, vf, va, led);
        tests_run++; if (hash_out !== exp_hash) begin tests_failed++; $display("FAIL b2b_hash_out: got %h expected %h", hash_out, exp_hash); end
        tests_run++; if (hash_valid !== exp_valid) begin tests_failed++; $display("FAIL b2b_hash_valid: got %b expected %b", hash_valid, exp_valid); end
        tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL b2b_overrun: got %b expected %b", overrun, exp_overrun); end
        pulse_ack();
    endtask

    task automatic test_overrun();
        logic [7:0] d [NBYTES];
        int fell; logic vf, va, led;
        rand_digest(d);
        send_digest(d, 1'b0, fell, vf, va, led);
        rand_digest(d);
        send_digest(d, 1'b0, fell, vf, va, led);
        tests_run++; if (hash_out !== exp_hash) begin tests_failed++; $display("FAIL ovr_hash_out: got %h expected %h", hash_out, exp_hash); end
        tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL ovr_set: got %b expected %b", overrun, exp_overrun); end
        repeat (50) @(negedge clk);
        pulse_ack();
        tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL ovr_sticky: got %b expected %b", overrun, exp_overrun); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        tests_run++; if (hash_out !== exp_hash) begin tests_failed++; $display("FAIL ovr_reset_hash: got %h expected %h", hash_out, exp_hash); end
        tests_run++; if (overrun !== exp_overrun) begin tests_failed++; $display("FAIL ovr_reset_overrun: got %b expected %b", overrun, exp_overrun); end
        tests_run++; if (hash_valid !== exp_valid) begin tests_failed++; $display("FAIL ovr_reset_valid: got %b expected %b", hash_valid, exp_valid); end
        tests_run++; if (frame_err !== 1'b0 || rx_led !== 1'b0) begin tests_failed++; $display("FAIL ovr_reset_misc: got %b%b expected 00", frame_err, rx_led); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_digest();
        test_ack();
        test_frame_err();
        test_gap_timeout();
        test_glitch();
        test_back_to_back();
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
